// File: rtl/alu_operand_loader_if.sv
// Handshake/bus bundle between the operand byte stream, the loader and the ALU logic units.
// slave is the loader's view; master is the view of whoever drives the stream and consumes pairs.
interface alu_operand_loader_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             flush;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_x;
   logic [WIDTH-1:0] out_y;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] pair_count;

   modport slave (
      input  flush, in_data, in_valid, out_ready,
      output in_ready, out_x, out_y, out_valid, pair_count
   );

   modport master (
      output flush, in_data, in_valid, out_ready,
      input  in_ready, out_x, out_y, out_valid, pair_count
   );
endinterface

// File: rtl/alu_operand_loader.sv
// Collects X then Y bytes from one stream and presents them as a held pair to the ALU units.
// Optional LOADER_OVERLAP_EN lets the next X be accepted in the same cycle the pair is consumed.
module alu_operand_loader #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_operand_loader_if.slave  bus
);

   typedef enum logic [1:0] {
      LOAD_X  = 2'd0,
      LOAD_Y  = 2'd1,
      PRESENT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             ready_s;
   logic             in_fire_s;

   // Input-side ready, decoded from state; forced low while reset is held.
   always_comb begin
      ready_s = 1'b0;
      case (state_q)
         LOAD_X:  ready_s = 1'b1;
         LOAD_Y:  ready_s = 1'b1;
`ifdef LOADER_OVERLAP_EN
         PRESENT: ready_s = bus.out_ready && !bus.flush;
`else
         PRESENT: ready_s = 1'b0;
`endif
         default: ready_s = 1'b0;
      endcase
   end

   assign in_fire_s = bus.in_valid && ready_s;

   // Next-state and capture logic; flush overrides every handshake.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      if (bus.flush) begin
         state_d = LOAD_X;
      end else begin
         case (state_q)
            LOAD_X: begin
               if (in_fire_s) begin
                  x_d     = bus.in_data;
                  state_d = LOAD_Y;
               end else begin
                  state_d = LOAD_X;
               end
            end
            LOAD_Y: begin
               if (in_fire_s) begin
                  y_d     = bus.in_data;
                  state_d = PRESENT;
               end else begin
                  state_d = LOAD_Y;
               end
            end
            PRESENT: begin
               if (bus.out_ready) begin
                  cnt_d = cnt_q + CNT_W'(1);
`ifdef LOADER_OVERLAP_EN
                  if (in_fire_s) begin
                     x_d     = bus.in_data;
                     state_d = LOAD_Y;
                  end else begin
                     state_d = LOAD_X;
                  end
`else
                  state_d = LOAD_X;
`endif
               end else begin
                  state_d = PRESENT;
               end
            end
            default: state_d = LOAD_X;
         endcase
      end
      valid_d = (state_d == PRESENT);
   end

   // State and operand registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD_X;
         x_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign bus.in_ready   = !rst && ready_s;
   assign bus.out_x      = x_q;
   assign bus.out_y      = y_q;
   assign bus.out_valid  = valid_q;
   assign bus.pair_count = cnt_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed self-checking bench for alu_operand_loader; expected values are hand-computed constants.
module tb_alu_operand_loader;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   alu_operand_loader_if #(.WIDTH(8), .CNT_W(8)) bus_if ();

   alu_operand_loader #(.WIDTH(8), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus_if.flush     = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.in_data   = 8'h00;
      bus_if.out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      do_reset();
      rst = 1'b1;
      #1;
      chk1("rst_in_ready", bus_if.in_ready, 1'b0);
      chk1("rst_valid", bus_if.out_valid, 1'b0);
      chk8("rst_x", bus_if.out_x, 8'h00);
      chk8("rst_y", bus_if.out_y, 8'h00);
      chk8("rst_cnt", bus_if.pair_count, 8'h00);
      rst = 1'b0;
      #1;
      chk1("idle_in_ready", bus_if.in_ready, 1'b1);

      // Basic pair A5/3C with out_ready high throughout
      bus_if.out_ready = 1'b1;
      bus_if.in_valid  = 1'b1;
      bus_if.in_data   = 8'hA5;
      step();
      chk8("t1_x", bus_if.out_x, 8'hA5);
      chk1("t1_valid_after_x", bus_if.out_valid, 1'b0);
      bus_if.in_data = 8'h3C;
      step();
      bus_if.in_valid = 1'b0;
      chk1("t1_valid", bus_if.out_valid, 1'b1);
      chk8("t1_y", bus_if.out_y, 8'h3C);
      chk8("t1_cnt_pre", bus_if.pair_count, 8'h00);
      step();
      chk1("t1_valid_drop", bus_if.out_valid, 1'b0);
      chk8("t1_cnt", bus_if.pair_count, 8'h01);
      chk8("t1_x_kept", bus_if.out_x, 8'hA5);
      chk8("t1_y_kept", bus_if.out_y, 8'h3C);

      // Hold FF/00 under backpressure with a blocked source
      do_reset();
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 8'hFF;
      step();
      bus_if.in_data = 8'h00;
      step();
      bus_if.in_data = 8'h77;
      for (int i = 0; i < 5; i++) begin
         chk1("t2_valid", bus_if.out_valid, 1'b1);
         chk8("t2_x", bus_if.out_x, 8'hFF);
         chk8("t2_y", bus_if.out_y, 8'h00);
         chk1("t2_in_ready", bus_if.in_ready, 1'b0);
         chk8("t2_cnt", bus_if.pair_count, 8'h00);
         step();
      end
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      step();
      chk8("t2_cnt_after", bus_if.pair_count, 8'h01);
      chk1("t2_valid_after", bus_if.out_valid, 1'b0);
      chk8("t2_x_after", bus_if.out_x, 8'hFF);

      // Flush in LOAD_Y drops X; flush beats a valid input byte
      do_reset();
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 8'h12;
      step();
      bus_if.flush   = 1'b1;
      bus_if.in_data = 8'h99;
      step();
      bus_if.flush = 1'b0;
      chk8("t3_x_after_flush", bus_if.out_x, 8'h12);
      chk8("t3_y_after_flush", bus_if.out_y, 8'h00);
      chk1("t3_in_ready", bus_if.in_ready, 1'b1);
      bus_if.in_data = 8'h34;
      step();
      bus_if.in_data = 8'h56;
      step();
      bus_if.in_valid = 1'b0;
      chk1("t3_valid", bus_if.out_valid, 1'b1);
      chk8("t3_x", bus_if.out_x, 8'h34);
      chk8("t3_y", bus_if.out_y, 8'h56);
      bus_if.out_ready = 1'b1;
      step();
      chk8("t3_cnt", bus_if.pair_count, 8'h01);

      // Flush with out_ready in PRESENT: no consumption counted
      do_reset();
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 8'hAA;
      step();
      bus_if.in_data = 8'hBB;
      step();
      bus_if.in_valid = 1'b0;
      chk1("t4_valid_pre", bus_if.out_valid, 1'b1);
      bus_if.flush     = 1'b1;
      bus_if.out_ready = 1'b1;
      #1;
      chk1("t4_in_ready_flush", bus_if.in_ready, 1'b0);
      step();
      bus_if.flush = 1'b0;
      chk1("t4_valid", bus_if.out_valid, 1'b0);
      chk8("t4_cnt", bus_if.pair_count, 8'h00);
      chk8("t4_x", bus_if.out_x, 8'hAA);
      chk8("t4_y", bus_if.out_y, 8'hBB);
      step();
      chk8("t4_cnt_idle", bus_if.pair_count, 8'h00);

      // 257 pairs: counter wraps at 256
      do_reset();
      bus_if.out_ready = 1'b1;
      for (int i = 0; i < 257; i++) begin
         bus_if.in_valid = 1'b1;
         bus_if.in_data  = i[7:0];
         step();
         bus_if.in_data = ~i[7:0];
         step();
         bus_if.in_valid = 1'b0;
         step();
         if (i == 254) chk8("t5_cnt_255", bus_if.pair_count, 8'hFF);
         if (i == 255) begin
            chk8("t5_cnt_wrap", bus_if.pair_count, 8'h00);
            chk8("t5_x_last", bus_if.out_x, 8'hFF);
            chk8("t5_y_last", bus_if.out_y, 8'h00);
         end
      end
      chk8("t5_cnt_257", bus_if.pair_count, 8'h01);

      // Asynchronous reset while presenting
      bus_if.out_ready = 1'b0;
      bus_if.in_valid  = 1'b1;
      bus_if.in_data   = 8'h5A;
      step();
      bus_if.in_data = 8'hC3;
      step();
      bus_if.in_valid = 1'b0;
      chk1("t6_valid_pre", bus_if.out_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk1("t6_valid", bus_if.out_valid, 1'b0);
      chk8("t6_x", bus_if.out_x, 8'h00);
      chk8("t6_y", bus_if.out_y, 8'h00);
      chk8("t6_cnt", bus_if.pair_count, 8'h00);
      chk1("t6_in_ready", bus_if.in_ready, 1'b0);
      step();
      rst = 1'b0;
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 8'h11;
      step();
      bus_if.in_data = 8'h22;
      step();
      bus_if.in_valid = 1'b0;
      chk8("t6_first_x", bus_if.out_x, 8'h11);
      chk8("t6_first_y", bus_if.out_y, 8'h22);
      chk1("t6_valid_post", bus_if.out_valid, 1'b1);

`ifdef LOADER_OVERLAP_EN
      // Overlapped stream 01..06: a pair every second cycle
      do_reset();
      bus_if.out_ready = 1'b1;
      bus_if.in_valid  = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         bus_if.in_data = i[7:0];
         step();
         chk1("t7_valid", bus_if.out_valid, (i % 2 == 0) ? 1'b1 : 1'b0);
         chk8("t7_x", bus_if.out_x, (i % 2 == 0) ? 8'(i - 1) : 8'(i));
         if (i % 2 == 0) chk8("t7_y", bus_if.out_y, 8'(i));
      end
      bus_if.in_valid = 1'b0;
      step();
      chk8("t7_cnt", bus_if.pair_count, 8'h03);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
